// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: maps CPU I/O addresses 252-255 onto a UART with a transmit FIFO and a receive latch.
// Transmit bytes are sent one at a time as a begin pulse, a busy rise, then a busy fall.
module uart_mmio_ctrl #(
    parameter int TX_DEPTH  = 4,
    parameter int BUSY_WAIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] w_data,
    input  logic       w_en,
    input  logic       rd_en,
    input  logic [7:0] mem_r_data_in,
    output logic [7:0] r_data,
    output logic       uart_tx_en,
    output logic       uart_rx_en,
    output logic       uart_begin,
    output logic [7:0] uart_tx_data,
    input  logic       uart_busy,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_valid
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state;
    logic [7:0]    fifo [TX_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, used;
    logic [CW-1:0] wait_cnt;
    logic [7:0]    rx_buf;
    logic          rx_valid, rx_overrun, tx_overflow;
    logic          full, empty, pop, push, accept, rx_pop, tx_active;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign used      = wr_ptr - rd_ptr;
    assign empty     = used == '0;
    assign full      = used == (AW+1)'(TX_DEPTH);
    assign pop       = state == IDLE && uart_tx_en && !empty;
    assign push      = w_en && addr == 8'd253;
    assign accept    = push && (!full || pop);
    assign rx_pop    = rd_en && addr == 8'd252;
    assign tx_active = !empty || state != IDLE;

    always_comb
        r_data = addr == 8'd255 ? {6'b0, uart_rx_en, uart_tx_en} :
                 addr == 8'd254 ? {3'b0, tx_overflow, rx_overrun, tx_active, rx_valid, full} :
                 addr == 8'd253 ? 8'h00 :
                 addr == 8'd252 ? rx_buf : mem_r_data_in;

    always_ff @(posedge clock)
        if (accept) fifo[wr_ptr[AW-1:0]] <= w_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_overflow <= 1'b0;
            uart_tx_en  <= 1'b0;
            uart_rx_en  <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !accept) tx_overflow <= 1'b1;
            else if (w_en && addr == 8'd254 && w_data[4]) tx_overflow <= 1'b0;
            if (w_en && addr == 8'd255) {uart_rx_en, uart_tx_en} <= w_data[1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            uart_begin   <= 1'b0;
            uart_tx_data <= 8'h00;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    uart_tx_data <= fifo[rd_ptr[AW-1:0]];
                    uart_begin   <= 1'b1;
                    state        <= LAUNCH;
                end
                LAUNCH: begin
                    uart_begin <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= WAIT_BUSY;
                end
                // A UART that never raises busy must not stall the queue.
                WAIT_BUSY: if (uart_busy || wait_cnt == CW'(BUSY_WAIT - 1)) state <= WAIT_DONE;
                           else wait_cnt <= wait_cnt + 1'b1;
                WAIT_DONE: if (!uart_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_buf     <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (w_en && addr == 8'd254 && w_data[3]) rx_overrun <= 1'b0;
            if (uart_rx_valid && uart_rx_en) begin
                if (!rx_valid || rx_pop) begin
                    rx_buf   <= uart_rx_data;
                    rx_valid <= 1'b1;
                end else rx_overrun <= 1'b1;
            end else if (rx_pop) rx_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: register-map vectors, directed UART handshake sequences,
// and randomized rx/tx traffic checked against a queue-based reference model.
module tb_uart_mmio_ctrl;
    localparam int DEPTH = 4;
    localparam int BW    = 4;

    logic       clock = 0, reset = 1;
    logic [7:0] addr = 0, w_data = 0, mem_r_data_in = 0, uart_rx_data = 0;
    logic       w_en = 0, rd_en = 0, uart_busy = 0, uart_rx_valid = 0;
    logic [7:0] r_data, uart_tx_data;
    logic       uart_tx_en, uart_rx_en, uart_begin;

    uart_mmio_ctrl #(.TX_DEPTH(DEPTH), .BUSY_WAIT(BW)) dut (
        .clock(clock), .reset(reset), .addr(addr), .w_data(w_data), .w_en(w_en),
        .rd_en(rd_en), .mem_r_data_in(mem_r_data_in), .r_data(r_data),
        .uart_tx_en(uart_tx_en), .uart_rx_en(uart_rx_en), .uart_begin(uart_begin),
        .uart_tx_data(uart_tx_data), .uart_busy(uart_busy),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0, cyc = 0, busy_mode = 0, wr_cyc = 0;
    logic [7:0] sent_q[$];
    int         begin_cyc[$];

    typedef struct {
        logic [7:0] a, d;
        logic       we, re;
        logic [7:0] mem;
        logic       c;
        logic [7:0] e;
    } vec_t;
    vec_t vt[18];

    initial forever begin @(posedge clock); cyc++; end

    // Every begin pulse seen is logged with the byte on uart_tx_data.
    initial forever begin
        @(negedge clock);
        if (uart_begin === 1'b1) begin
            sent_q.push_back(uart_tx_data);
            begin_cyc.push_back(cyc);
        end
    end

    // UART model: busy rises the cycle after begin and stays high for 10 cycles.
    initial forever begin
        @(negedge clock);
        if (uart_begin === 1'b1 && busy_mode == 0) begin
            @(posedge clock); #1 uart_busy = 1;
            repeat (10) @(posedge clock);
            #1 uart_busy = 0;
        end
    end

    initial begin #500000; $display("FAIL watchdog: got timeout want finish"); $fatal(1); end

    task automatic tick(); @(posedge clock); #1; endtask
    task automatic idle(int n); repeat (n) tick(); endtask

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wr(logic [7:0] a, logic [7:0] d);
        addr = a; w_data = d; w_en = 1; wr_cyc = cyc;
        tick();
        w_en = 0; addr = 0;
    endtask

    task automatic peek(string nm, logic [7:0] a, logic [7:0] exp);
        addr = a; #1 chk(nm, r_data, exp);
        tick();
        addr = 0;
    endtask

    task automatic rd(string nm, logic [7:0] a, logic [7:0] exp);
        addr = a; rd_en = 1; #1 chk(nm, r_data, exp);
        tick();
        rd_en = 0; addr = 0;
    endtask

    task automatic rx_pulse(logic [7:0] d);
        uart_rx_data = d; uart_rx_valid = 1;
        tick();
        uart_rx_valid = 0;
    endtask

    task automatic wait_sent(string nm, int n, int budget);
        int i = 0;
        while (sent_q.size() < n && i < budget) begin tick(); i++; end
        total++;
        if (sent_q.size() < n) begin
            bad++;
            $display("FAIL %s: got %0d begins want %0d", nm, sent_q.size(), n);
        end
    endtask

    function automatic vec_t mk(logic [7:0] a, logic [7:0] d, logic we, logic re,
                                logic [7:0] mem, logic c, logic [7:0] e);
        vec_t v;
        v.a = a; v.d = d; v.we = we; v.re = re; v.mem = mem; v.c = c; v.e = e;
        return v;
    endfunction

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] r, d, e;
        logic       m_valid, m_ovr, m_rxen, rxv, pop;
        logic [7:0] m_buf;
        int         op, n, k;

        vt[0]  = mk(8'd255, 8'h00, 0, 0, 8'h00, 1, 8'h00);
        vt[1]  = mk(8'd254, 8'h00, 0, 0, 8'h00, 1, 8'h00);
        vt[2]  = mk(8'd253, 8'h00, 0, 0, 8'h00, 1, 8'h00);
        vt[3]  = mk(8'd252, 8'h00, 0, 0, 8'h00, 1, 8'h00);
        vt[4]  = mk(8'h20,  8'h00, 0, 1, 8'h77, 1, 8'h77);
        vt[5]  = mk(8'h20,  8'hFF, 1, 0, 8'h12, 1, 8'h12);
        vt[6]  = mk(8'd255, 8'h00, 0, 0, 8'h00, 1, 8'h00);
        vt[7]  = mk(8'd254, 8'h00, 0, 0, 8'h00, 1, 8'h00);
        vt[8]  = mk(8'd255, 8'h02, 1, 0, 8'h00, 0, 8'h00);
        vt[9]  = mk(8'd255, 8'h00, 0, 0, 8'h00, 1, 8'h02);
        vt[10] = mk(8'd252, 8'h99, 1, 0, 8'h00, 0, 8'h00);
        vt[11] = mk(8'd252, 8'h00, 0, 0, 8'h00, 1, 8'h00);
        vt[12] = mk(8'd254, 8'hFF, 1, 0, 8'h00, 0, 8'h00);
        vt[13] = mk(8'd254, 8'h00, 0, 0, 8'h00, 1, 8'h00);
        vt[14] = mk(8'd255, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        vt[15] = mk(8'd255, 8'h00, 0, 0, 8'h00, 1, 8'h00);
        vt[16] = mk(8'hFB,  8'h00, 0, 1, 8'h3C, 1, 8'h3C);
        vt[17] = mk(8'h00,  8'h00, 0, 0, 8'hA5, 1, 8'hA5);

        // Reset state
        idle(2);
        chk("rst_ctrl", {5'b0, uart_tx_en, uart_rx_en, uart_begin}, 8'h00);
        chk("rst_txd", uart_tx_data, 8'h00);
        reset = 0;
        tick();

        foreach (vt[i]) begin
            addr = vt[i].a; w_data = vt[i].d; w_en = vt[i].we; rd_en = vt[i].re;
            mem_r_data_in = vt[i].mem;
            #1 if (vt[i].c) chk($sformatf("vec%0d", i), r_data, vt[i].e);
            tick();
            w_en = 0; rd_en = 0; addr = 0; mem_r_data_in = 0;
        end

        // Single byte: begin two cycles after the write, STATUS active until busy falls
        wr(8'd255, 8'h03);
        wr(8'd253, 8'h41);
        k = wr_cyc;
        wait_sent("t1_begin", 1, 20);
        if (sent_q.size() > 0) begin
            chk("t1_latency", 8'(begin_cyc[0] - k), 8'd2);
            chk("t1_data", sent_q[0], 8'h41);
        end
        peek("t1_active", 8'd254, 8'h04);
        n = 0;
        while (uart_busy && n < 30) begin tick(); n++; end
        chk("t1_busy_fall", {7'b0, uart_busy}, 8'h00);
        idle(2);
        peek("t1_done", 8'd254, 8'h00);
        chk("t1_one_begin", 8'(sent_q.size()), 8'd1);

        // Overflow: five pushes into a four-entry FIFO with tx disabled
        wr(8'd255, 8'h00);
        sent_q.delete(); begin_cyc.delete();
        for (int i = 0; i < 5; i++) wr(8'd253, 8'(8'h10 + i));
        peek("t2_status", 8'd254, 8'h15);
        wr(8'd255, 8'h01);
        wait_sent("t2_sent", 4, 200);
        idle(30);
        chk("t2_count", 8'(sent_q.size()), 8'd4);
        for (int i = 0; i < 4 && i < sent_q.size(); i++)
            chk($sformatf("t2_byte%0d", i), sent_q[i], 8'(8'h10 + i));
        peek("t2_ovf", 8'd254, 8'h10);
        wr(8'd254, 8'h10);
        peek("t2_w1c", 8'd254, 8'h00);

        // Busy never rises: timeout path keeps the queue moving
        busy_mode = 1;
        sent_q.delete(); begin_cyc.delete();
        wr(8'd253, 8'hC1);
        k = wr_cyc;
        wr(8'd253, 8'hC2);
        wait_sent("t3_sent", 2, 60);
        if (sent_q.size() >= 2) begin
            chk("t3_latency", 8'(begin_cyc[0] - k), 8'd2);
            chk("t3_gap", 8'(begin_cyc[1] - begin_cyc[0]), 8'(BW + 3));
            chk("t3_b0", sent_q[0], 8'hC1);
            chk("t3_b1", sent_q[1], 8'hC2);
        end
        idle(10);
        busy_mode = 0;
        peek("t3_idle", 8'd254, 8'h00);

        // Receive path
        wr(8'd255, 8'h02);
        rx_pulse(8'h5A);
        peek("t4_valid", 8'd254, 8'h02);
        rx_pulse(8'hA5);
        peek("t4_overrun", 8'd254, 8'h0A);
        peek("t4_keep", 8'd252, 8'h5A);
        rd("t4_pop", 8'd252, 8'h5A);
        peek("t4_popped", 8'd254, 8'h08);
        wr(8'd254, 8'h08);
        peek("t4_w1c", 8'd254, 8'h00);
        rx_pulse(8'h11);
        addr = 8'd252; rd_en = 1; uart_rx_data = 8'h22; uart_rx_valid = 1;
        #1 chk("t4_same_rd", r_data, 8'h11);
        tick();
        rd_en = 0; uart_rx_valid = 0; addr = 0;
        peek("t4_same_buf", 8'd252, 8'h22);
        peek("t4_same_st", 8'd254, 8'h02);
        rd("t4_pop2", 8'd252, 8'h22);
        wr(8'd255, 8'h00);
        rx_pulse(8'h33);
        peek("t4_off_st", 8'd254, 8'h00);
        peek("t4_off_buf", 8'd252, 8'h22);

        // Reset while in WAIT_DONE with two bytes still queued
        sent_q.delete(); begin_cyc.delete();
        wr(8'd253, 8'h71); wr(8'd253, 8'h72); wr(8'd253, 8'h73);
        wr(8'd255, 8'h01);
        wait_sent("t5_first", 1, 20);
        idle(3);
        #2 reset = 1;
        #1 chk("t5_ctrl", {5'b0, uart_tx_en, uart_rx_en, uart_begin}, 8'h00);
        chk("t5_txd", uart_tx_data, 8'h00);
        addr = 8'd254;
        #1 chk("t5_status_rst", r_data, 8'h00);
        addr = 0;
        tick(); tick();
        reset = 0;
        peek("t5_status", 8'd254, 8'h00);
        idle(30);
        chk("t5_no_begin", 8'(sent_q.size()), 8'd1);

        // Randomized rx/ctrl/passthrough traffic against the reference model
        m_valid = 0; m_ovr = 0; m_rxen = 0; m_buf = 8'h00;
        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 6);
            d = 8'($urandom);
            r = 8'($urandom);
            rxv = ($urandom_range(0, 2) == 0) && op != 4;
            mem_r_data_in = 8'($urandom);
            uart_rx_data = d; uart_rx_valid = rxv;
            case (op)
                0: begin addr = 8'd252; rd_en = 1; end
                1: addr = 8'd254;
                2: addr = 8'd255;
                3: begin addr = 8'd255; w_data = r & 8'hFE; w_en = 1; end
                4: begin addr = 8'd254; w_data = r; w_en = 1; end
                5: begin addr = 8'($urandom_range(0, 251)); w_data = r; w_en = 1; end
                default: begin addr = 8'($urandom_range(0, 251)); rd_en = 1'($urandom); end
            endcase
            e = addr == 8'd255 ? {6'b0, m_rxen, 1'b0} :
                addr == 8'd254 ? {4'b0, m_ovr, 1'b0, m_valid, 1'b0} :
                addr == 8'd252 ? m_buf : mem_r_data_in;
            #1 chk("rand_rx", r_data, e);
            tick();
            w_en = 0; rd_en = 0; uart_rx_valid = 0; addr = 0;
            pop = op == 0;
            if (rxv && m_rxen) begin
                if (m_valid && !pop) m_ovr = 1;
                else begin m_buf = d; m_valid = 1; end
            end else if (pop) m_valid = 0;
            if (op == 4 && r[3]) m_ovr = 0;
            if (op == 3) m_rxen = r[1];
        end

        // Randomized tx rounds: bursts of 1..6 bytes into a DEPTH-entry FIFO
        reset = 1; tick(); reset = 0; tick();
        for (int rnd = 0; rnd < 6; rnd++) begin
            wr(8'd255, 8'h00);
            sent_q.delete(); begin_cyc.delete(); exp_q.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                if (exp_q.size() < DEPTH) exp_q.push_back(d);
                wr(8'd253, d);
            end
            peek("rtx_status", 8'd254,
                 {3'b0, 1'(n > DEPTH), 1'b0, 1'b1, 1'b0, 1'(n >= DEPTH)});
            wr(8'd255, 8'h01);
            wait_sent("rtx_sent", exp_q.size(), 300);
            idle(20);
            chk("rtx_count", 8'(sent_q.size()), 8'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
                chk("rtx_byte", sent_q[i], exp_q[i]);
            peek("rtx_end", 8'd254, n > DEPTH ? 8'h10 : 8'h00);
            wr(8'd254, 8'h10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
